// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched
// Two-road (NS/EW) intersection phase scheduler. Sequences green -> yellow ->
// all-red for each road with programmable dwell times counted in slow_clk ticks.
// A latched pedestrian request inserts a WALK phase at the next all-red exit.
// A hold input freezes the phase and its dwell counter. The LED bank, phase code,
// change pulse, walk flag and pending flag are all registered outputs.
module traffic_phase_sched #(
  parameter int T_GREEN  = 5,
  parameter int T_YELLOW = 2,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 4,
  parameter int CW       = 4
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic       ped_req,
  input  logic       hold,
  output logic [5:0] led,
  output logic       walk,
  output logic [2:0] phase,
  output logic       phase_chg,
  output logic       ped_pend
);

  typedef enum logic [2:0] {
    PH_NS_G = 3'd0,
    PH_NS_Y = 3'd1,
    PH_AR_A = 3'd2,
    PH_EW_G = 3'd3,
    PH_EW_Y = 3'd4,
    PH_AR_B = 3'd5,
    PH_WALK = 3'd6,
    PH_BAD  = 3'd7
  } phase_t;

  // Counter load values: a phase lasting T ticks starts at T-1 and advances at 0.
  localparam logic [CW-1:0] LD_GREEN  = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] LD_YELLOW = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] LD_ALLRED = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] LD_WALK   = CW'(T_WALK - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Lamp pattern for a phase: {EW red, EW yel, EW grn, NS red, NS yel, NS grn}.
  function automatic logic [5:0] led_decode(input phase_t ph);
    logic [5:0] pat;
    case (ph)
      PH_NS_G: pat = 6'b100001;
      PH_NS_Y: pat = 6'b100010;
      PH_AR_A: pat = 6'b100100;
      PH_EW_G: pat = 6'b001100;
      PH_EW_Y: pat = 6'b010100;
      PH_AR_B: pat = 6'b100100;
      PH_WALK: pat = 6'b100100;
      default: pat = 6'b111111;
    endcase
    return pat;
  endfunction

  // Dwell counter load value on entry to a phase.
  function automatic logic [CW-1:0] dwell_load(input phase_t ph);
    logic [CW-1:0] ld;
    case (ph)
      PH_NS_G: ld = LD_GREEN;
      PH_NS_Y: ld = LD_YELLOW;
      PH_AR_A: ld = LD_ALLRED;
      PH_EW_G: ld = LD_GREEN;
      PH_EW_Y: ld = LD_YELLOW;
      PH_AR_B: ld = LD_ALLRED;
      PH_WALK: ld = LD_WALK;
      default: ld = LD_GREEN;
    endcase
    return ld;
  endfunction

  phase_t        phase_r;
  phase_t        phase_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          nxt_ew_r;
  logic          nxt_ew_nxt_s;
  logic          ped_q_r;
  logic          ped_pend_r;
  logic          ped_pend_nxt_s;
  logic          chg_nxt_s;
  logic          walk_entry_s;
  logic          ped_rise_s;
  logic          ped_req_eff_s;
  logic [5:0]    led_r;
  logic          walk_r;
  logic          phase_chg_r;

  // Button edge detect; a fresh press counts at an all-red exit on the same edge,
  // but presses made while WALK is already showing are discarded.
  always_comb begin
    ped_rise_s    = ped_req & ~ped_q_r;
    ped_req_eff_s = ped_pend_r | (ped_rise_s & (phase_r != PH_WALK));
  end

  // Next phase, dwell counter and resume-direction selection.
  always_comb begin
    phase_nxt_s  = phase_r;
    cnt_nxt_s    = cnt_r;
    nxt_ew_nxt_s = nxt_ew_r;
    chg_nxt_s    = 1'b0;
    walk_entry_s = 1'b0;
    if (phase_r == PH_BAD) begin
      // Corrupted phase code: fall back to a known-safe start immediately.
      phase_nxt_s = PH_NS_G;
      cnt_nxt_s   = LD_GREEN;
      chg_nxt_s   = ~hold;
    end else if (hold) begin
      phase_nxt_s = phase_r;
      cnt_nxt_s   = cnt_r;
    end else if (cnt_r != CNT_ZERO) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      case (phase_r)
        PH_NS_G: phase_nxt_s = PH_NS_Y;
        PH_NS_Y: phase_nxt_s = PH_AR_A;
        PH_AR_A: begin
          if (ped_req_eff_s) begin
            phase_nxt_s  = PH_WALK;
            nxt_ew_nxt_s = 1'b1;
            walk_entry_s = 1'b1;
          end else begin
            phase_nxt_s = PH_EW_G;
          end
        end
        PH_EW_G: phase_nxt_s = PH_EW_Y;
        PH_EW_Y: phase_nxt_s = PH_AR_B;
        PH_AR_B: begin
          if (ped_req_eff_s) begin
            phase_nxt_s  = PH_WALK;
            nxt_ew_nxt_s = 1'b0;
            walk_entry_s = 1'b1;
          end else begin
            phase_nxt_s = PH_NS_G;
          end
        end
        PH_WALK: begin
          if (nxt_ew_r) begin
            phase_nxt_s = PH_EW_G;
          end else begin
            phase_nxt_s = PH_NS_G;
          end
        end
        default: phase_nxt_s = PH_NS_G;
      endcase
      cnt_nxt_s = dwell_load(phase_nxt_s);
      chg_nxt_s = 1'b1;
    end
  end

  // Pending request: cleared when WALK is entered, otherwise set by a qualified press.
  always_comb begin
    if (walk_entry_s) begin
      ped_pend_nxt_s = 1'b0;
    end else if (ped_rise_s && (phase_r != PH_WALK)) begin
      ped_pend_nxt_s = 1'b1;
    end else begin
      ped_pend_nxt_s = ped_pend_r;
    end
  end

  // State and output registers; LEDs and walk are decoded from the next phase so
  // they change on the same edge as the phase code.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      phase_r     <= PH_NS_G;
      cnt_r       <= LD_GREEN;
      nxt_ew_r    <= 1'b0;
      ped_q_r     <= 1'b0;
      ped_pend_r  <= 1'b0;
      led_r       <= 6'b100001;
      walk_r      <= 1'b0;
      phase_chg_r <= 1'b0;
    end else begin
      phase_r     <= phase_nxt_s;
      cnt_r       <= cnt_nxt_s;
      nxt_ew_r    <= nxt_ew_nxt_s;
      ped_q_r     <= ped_req;
      ped_pend_r  <= ped_pend_nxt_s;
      led_r       <= led_decode(phase_nxt_s);
      walk_r      <= (phase_nxt_s == PH_WALK);
      phase_chg_r <= chg_nxt_s;
    end
  end

  assign led       = led_r;
  assign walk      = walk_r;
  assign phase     = phase_r;
  assign phase_chg = phase_chg_r;
  assign ped_pend  = ped_pend_r;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched. Inputs change and outputs are sampled
// on the falling edge; each rising edge is one scheduler tick.
module tb_traffic_phase_sched;

  logic       slow_clk;
  logic       rst;
  logic       ped_req;
  logic       hold;
  logic [5:0] led;
  logic       walk;
  logic [2:0] phase;
  logic       phase_chg;
  logic       ped_pend;

  int errors = 0;
  int checks = 0;

  traffic_phase_sched dut (
    .slow_clk (slow_clk),
    .rst      (rst),
    .ped_req  (ped_req),
    .hold     (hold),
    .led      (led),
    .walk     (walk),
    .phase    (phase),
    .phase_chg(phase_chg),
    .ped_pend (ped_pend)
  );

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  // Lamp decode table for legal phase codes.
  function automatic logic [5:0] exp_led(input int ph);
    case (ph)
      0: return 6'b100001;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b001100;
      4: return 6'b010100;
      5: return 6'b100100;
      6: return 6'b100100;
      default: return 6'b111111;
    endcase
  endfunction

  // Hold reset across two edges, release on a falling edge (that sample is tick 0).
  task automatic do_reset();
    rst = 1'b1;
    ped_req = 1'b0;
    hold = 1'b0;
    @(negedge slow_clk);
    @(negedge slow_clk);
    rst = 1'b0;
  endtask

  task automatic check_phase_led(input string name, input int k, input int ph);
    logic [2:0] ep;
    ep = 3'(ph);
    checks++;
    if (phase !== ep) begin
      errors++;
      $display("FAIL %s phase k=%0d: got %0d expected %0d", name, k, phase, ep);
    end
    checks++;
    if (led !== exp_led(ph)) begin
      errors++;
      $display("FAIL %s led k=%0d: got %b expected %b", name, k, led, exp_led(ph));
    end
    checks++;
    if (walk !== (ph == 6)) begin
      errors++;
      $display("FAIL %s walk k=%0d: got %b expected %b", name, k, walk, (ph == 6));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ped_req = 1'b0;
    hold = 1'b0;
    @(negedge slow_clk);
    @(negedge slow_clk);
    check_phase_led("reset", 0, 0);
    checks++;
    if (phase_chg !== 1'b0) begin
      errors++;
      $display("FAIL reset phase_chg: got %b expected 0", phase_chg);
    end
    checks++;
    if (ped_pend !== 1'b0) begin
      errors++;
      $display("FAIL reset ped_pend: got %b expected 0", ped_pend);
    end
  endtask

  task automatic test_base_sequence();
    int seq[16];
    int chg_cnt;
    logic exp_chg;
    seq = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 4, 4, 5};
    chg_cnt = 0;
    do_reset();
    for (int k = 0; k <= 32; k++) begin
      check_phase_led("base", k, seq[k % 16]);
      if (k == 0) exp_chg = 1'b0;
      else exp_chg = (seq[k % 16] != seq[(k - 1) % 16]);
      checks++;
      if (phase_chg !== exp_chg) begin
        errors++;
        $display("FAIL base phase_chg k=%0d: got %b expected %b", k, phase_chg, exp_chg);
      end
      if (phase_chg === 1'b1) chg_cnt++;
      @(negedge slow_clk);
    end
    checks++;
    if (chg_cnt !== 12) begin
      errors++;
      $display("FAIL base chg_count: got %0d expected 12", chg_cnt);
    end
  endtask

  task automatic test_ped_walk();
    int seq[21];
    logic exp_pend;
    seq = '{0, 0, 0, 0, 0, 1, 1, 2, 6, 6, 6, 6, 3, 3, 3, 3, 3, 4, 4, 5, 0};
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      if (k == 2) ped_req = 1'b1;
      check_phase_led("ped_walk", k, seq[k]);
      exp_pend = (k >= 3 && k <= 7);
      checks++;
      if (ped_pend !== exp_pend) begin
        errors++;
        $display("FAIL ped_walk ped_pend k=%0d: got %b expected %b", k, ped_pend, exp_pend);
      end
      @(negedge slow_clk);
    end
    ped_req = 1'b0;
  endtask

  task automatic test_held_button(input bit retrigger);
    int walks;
    string name;
    name = retrigger ? "ped_retrig" : "ped_held";
    walks = 0;
    do_reset();
    ped_req = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      if (k == 8) begin
        checks++;
        if (phase !== 3'd6) begin
          errors++;
          $display("FAIL %s walk_entry: got %0d expected 6", name, phase);
        end
      end
      if (retrigger && k == 8) ped_req = 1'b0;
      if (retrigger && k == 9) ped_req = 1'b1;
      if (k >= 10 && k <= 11) begin
        checks++;
        if (ped_pend !== 1'b0) begin
          errors++;
          $display("FAIL %s pend_in_walk k=%0d: got %b expected 0", name, k, ped_pend);
        end
      end
      if (k >= 1 && phase_chg === 1'b1 && phase === 3'd6) walks++;
      @(negedge slow_clk);
    end
    checks++;
    if (walks !== 1) begin
      errors++;
      $display("FAIL %s walk_count: got %0d expected 1", name, walks);
    end
    checks++;
    if (ped_pend !== 1'b0) begin
      errors++;
      $display("FAIL %s final ped_pend: got %b expected 0", name, ped_pend);
    end
    ped_req = 1'b0;
  endtask

  task automatic test_hold();
    int seq[17];
    seq = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 3, 3, 3, 3, 3, 4};
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      if (k == 6) hold = 1'b1;
      if (k == 9) hold = 1'b0;
      check_phase_led("hold", k, seq[k]);
      if (k >= 7 && k <= 10) begin
        checks++;
        if (phase_chg !== (k == 10)) begin
          errors++;
          $display("FAIL hold phase_chg k=%0d: got %b expected %b", k, phase_chg, (k == 10));
        end
      end
      @(negedge slow_clk);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k == 9) ped_req = 1'b1;
      @(negedge slow_clk);
    end
    check_phase_led("mid_rst pre", 10, 3);
    checks++;
    if (ped_pend !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst pre ped_pend: got %b expected 1", ped_pend);
    end
    #2;
    rst = 1'b1;
    ped_req = 1'b0;
    #1;
    check_phase_led("mid_rst async", 0, 0);
    checks++;
    if (ped_pend !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst async ped_pend: got %b expected 0", ped_pend);
    end
    @(negedge slow_clk);
    rst = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      check_phase_led("mid_rst after", k, (k <= 4) ? 0 : 1);
      @(negedge slow_clk);
    end
  endtask

  task automatic test_ped_last_allred();
    int seq[21];
    seq = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 4, 4, 5, 6, 6, 6, 6, 0};
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      if (k == 15) begin
        checks++;
        if (ped_pend !== 1'b0) begin
          errors++;
          $display("FAIL arb_edge pre ped_pend: got %b expected 0", ped_pend);
        end
        ped_req = 1'b1;
      end
      check_phase_led("arb_edge", k, seq[k]);
      if (k >= 16) begin
        checks++;
        if (ped_pend !== 1'b0) begin
          errors++;
          $display("FAIL arb_edge ped_pend k=%0d: got %b expected 0", k, ped_pend);
        end
      end
      @(negedge slow_clk);
    end
    ped_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ped_req = 1'b0;
    hold = 1'b0;
    test_reset();
    test_base_sequence();
    test_ped_walk();
    test_held_button(1'b0);
    test_held_button(1'b1);
    test_hold();
    test_mid_reset();
    test_ped_last_allred();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
